rsa_core_arbiter: RTL and testbench

Shares one `Rsa256Core` between `NUM_REQ` independent requesters, such as multiple Avalon/UART front-ends or a host-side test port. Each requester hands over an operand set (a, d, n). The arbiter grants requesters round-robin, latches the operands, and sequences the core's start/finish handshake. It returns the result to the granted requester over a valid/ready response channel. It sits between the front-end wrappers and the single core instance.

---
 rtl/rsa_core_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_rsa_core_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter that shares a single Rsa256Core between NUM_REQ
// requesters. It accepts one operand set at a time, pulses the core start,
// waits for the core to finish and then returns the result to the owner
// over a valid/ready response channel.
module rsa_core_arbiter #(
    parameter int BITWIDTH = 256,
    parameter int NUM_REQ  = 2,
    localparam int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        avm_clk,
    input  logic                        avm_rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*BITWIDTH-1:0] req_a,
    input  logic [NUM_REQ*BITWIDTH-1:0] req_d,
    input  logic [NUM_REQ*BITWIDTH-1:0] req_n,
    output logic [NUM_REQ-1:0]          resp_valid,
    input  logic [NUM_REQ-1:0]          resp_ready,
    output logic [BITWIDTH-1:0]         resp_data,
    output logic [GID_W-1:0]            grant_id,
    output logic                        busy,
    output logic                        core_start,
    output logic [BITWIDTH-1:0]         core_a,
    output logic [BITWIDTH-1:0]         core_d,
    output logic [BITWIDTH-1:0]         core_n,
    input  logic [BITWIDTH-1:0]         core_result,
    input  logic                        core_finished
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [GID_W-1:0]      last_grant_r;
    logic [GID_W-1:0]      grant_id_r;
    logic [GID_W-1:0]      winner_s;
    logic                  found_s;
    logic                  accept_s;
    logic                  finish_s;
    logic                  resp_fire_s;
    logic                  core_start_r;
    logic                  busy_r;
    logic [NUM_REQ-1:0]    resp_valid_r;
    logic [NUM_REQ-1:0]    grant_onehot_s;
    logic [BITWIDTH-1:0]   resp_data_r;
    logic [BITWIDTH-1:0]   core_a_r;
    logic [BITWIDTH-1:0]   core_d_r;
    logic [BITWIDTH-1:0]   core_n_r;
    logic [BITWIDTH-1:0]   sel_a_s;
    logic [BITWIDTH-1:0]   sel_d_s;
    logic [BITWIDTH-1:0]   sel_n_s;
    logic [GID_W:0]        sum_v;

    // Round-robin winner: scan from last_grant+1 upward with an explicit
    // wrap so non-power-of-two NUM_REQ never yields an out-of-range index.
    // Scanning offsets from the far end down lets the nearest hit win.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        sum_v    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum_v = {1'b0, last_grant_r} + (GID_W+1)'(k);
            if (sum_v >= (GID_W+1)'(NUM_REQ)) begin
                sum_v = sum_v - (GID_W+1)'(NUM_REQ);
            end else begin
                sum_v = sum_v;
            end
            if (req_valid[sum_v[GID_W-1:0]]) begin
                winner_s = sum_v[GID_W-1:0];
                found_s  = 1'b1;
            end else begin
                winner_s = winner_s;
                found_s  = found_s;
            end
        end
    end

    // Operand mux for the current winner plus one-hot decodes of the winner
    // (for req_ready) and of the latched grant (for resp_valid).
    always_comb begin
        sel_a_s        = '0;
        sel_d_s        = '0;
        sel_n_s        = '0;
        req_ready      = '0;
        grant_onehot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_s == GID_W'(i)) begin
                sel_a_s      = req_a[i*BITWIDTH +: BITWIDTH];
                sel_d_s      = req_d[i*BITWIDTH +: BITWIDTH];
                sel_n_s      = req_n[i*BITWIDTH +: BITWIDTH];
                req_ready[i] = (state_r == ST_IDLE) && found_s;
            end else begin
                req_ready[i] = 1'b0;
            end
            if (grant_id_r == GID_W'(i)) begin
                grant_onehot_s[i] = 1'b1;
            end else begin
                grant_onehot_s[i] = 1'b0;
            end
        end
    end

    // Handshake qualifiers; core_finished only counts while waiting in BUSY.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && found_s;
        finish_s    = (state_r == ST_BUSY) && core_finished;
        resp_fire_s = (state_r == ST_RESP) && resp_ready[grant_id_r];
    end

    // Next-state logic for the IDLE -> ISSUE -> BUSY -> RESP loop.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_BUSY;
            end
            ST_BUSY: begin
                if (finish_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (resp_fire_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus the registered start pulse and busy flag.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_r      <= ST_IDLE;
            core_start_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            core_start_r <= accept_s;
            busy_r       <= (state_next_s != ST_IDLE);
        end
    end

    // Operand and grant capture; changes only on an accepted request.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            core_a_r   <= '0;
            core_d_r   <= '0;
            core_n_r   <= '0;
            grant_id_r <= '0;
        end else if (accept_s) begin
            core_a_r   <= sel_a_s;
            core_d_r   <= sel_d_s;
            core_n_r   <= sel_n_s;
            grant_id_r <= winner_s;
        end
    end

    // Response path: capture the result, steer valid to the owner, and
    // advance the round-robin pointer once the owner takes the result.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            resp_data_r  <= '0;
            resp_valid_r <= '0;
            last_grant_r <= GID_W'(NUM_REQ - 1);
        end else begin
            if (finish_s) begin
                resp_data_r  <= core_result;
                resp_valid_r <= grant_onehot_s;
            end else if (resp_fire_s) begin
                resp_valid_r <= '0;
            end
            if (resp_fire_s) begin
                last_grant_r <= grant_id_r;
            end
        end
    end

    assign core_start = core_start_r;
    assign busy       = busy_r;
    assign grant_id   = grant_id_r;
    assign core_a     = core_a_r;
    assign core_d     = core_d_r;
    assign core_n     = core_n_r;
    assign resp_data  = resp_data_r;
    assign resp_valid = resp_valid_r;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Directed bench for rsa_core_arbiter: a 2-requester instance at full width
// and a 3-requester narrow instance for the non-power-of-two wrap.
module tb_rsa_core_arbiter;

    logic avm_clk;
    logic avm_rst;

    // NUM_REQ=2, BITWIDTH=256 instance
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [511:0] req_a;
    logic [511:0] req_d;
    logic [511:0] req_n;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [255:0] resp_data;
    logic [0:0]   grant_id;
    logic         busy;
    logic         core_start;
    logic [255:0] core_a;
    logic [255:0] core_d;
    logic [255:0] core_n;
    logic [255:0] core_result;
    logic         core_finished;

    // NUM_REQ=3, BITWIDTH=8 instance
    logic [2:0]   r3_valid;
    logic [2:0]   r3_ready;
    logic [23:0]  r3_a;
    logic [23:0]  r3_d;
    logic [23:0]  r3_n;
    logic [2:0]   r3_resp_valid;
    logic [2:0]   r3_resp_ready;
    logic [7:0]   r3_resp_data;
    logic [1:0]   r3_grant_id;
    logic         r3_busy;
    logic         r3_core_start;
    logic [7:0]   r3_core_a;
    logic [7:0]   r3_core_d;
    logic [7:0]   r3_core_n;
    logic [7:0]   r3_core_result;
    logic         r3_core_finished;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;
    int viol;
    logic [1:0] exp_oh;
    logic [1:0] exp_g;
    logic [2:0] exp3_oh;
    logic [1:0] exp3_g;

    rsa_core_arbiter #(.BITWIDTH(256), .NUM_REQ(2)) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_d(req_d), .req_n(req_n),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .grant_id(grant_id), .busy(busy), .core_start(core_start),
        .core_a(core_a), .core_d(core_d), .core_n(core_n),
        .core_result(core_result), .core_finished(core_finished)
    );

    rsa_core_arbiter #(.BITWIDTH(8), .NUM_REQ(3)) dut3 (
        .avm_clk(avm_clk), .avm_rst(avm_rst),
        .req_valid(r3_valid), .req_ready(r3_ready),
        .req_a(r3_a), .req_d(r3_d), .req_n(r3_n),
        .resp_valid(r3_resp_valid), .resp_ready(r3_resp_ready), .resp_data(r3_resp_data),
        .grant_id(r3_grant_id), .busy(r3_busy), .core_start(r3_core_start),
        .core_a(r3_core_a), .core_d(r3_core_d), .core_n(r3_core_n),
        .core_result(r3_core_result), .core_finished(r3_core_finished)
    );

    initial avm_clk = 1'b0;
    always #5 avm_clk = ~avm_clk;

    task automatic tick();
        @(posedge avm_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        pass_cnt = 0; fail_cnt = 0; total_cnt = 0; viol = 0;
        avm_rst = 1'b1;
        req_valid = 2'b00; resp_ready = 2'b00;
        req_a = '0; req_d = '0; req_n = '0;
        core_result = '0; core_finished = 1'b0;
        r3_valid = 3'b000; r3_resp_ready = 3'b000;
        r3_a = '0; r3_d = '0; r3_n = '0;
        r3_core_result = '0; r3_core_finished = 1'b0;
        tick(); tick();

        // reset state
        check("rst_busy", 256'(busy), 256'(1'b0));
        check("rst_start", 256'(core_start), 256'(1'b0));
        check("rst_resp_valid", 256'(resp_valid), 256'(2'b00));
        check("rst_grant", 256'(grant_id), 256'(1'b0));
        check("rst_resp_data", resp_data, 256'(0));
        check("rst_core_a", core_a, 256'(0));
        avm_rst = 1'b0;
        tick();

        // single request from requester 1
        req_a[256 +: 256] = 256'h2;
        req_d[256 +: 256] = 256'h5;
        req_n[256 +: 256] = 256'hB;
        req_a[0 +: 256]   = 256'h3;
        req_d[0 +: 256]   = 256'h13;
        req_n[0 +: 256]   = 256'h23;
        req_valid = 2'b10;
        #1;
        check("single_req_ready", 256'(req_ready), 256'(2'b10));
        tick();
        req_valid = 2'b00;
        check("single_start", 256'(core_start), 256'(1'b1));
        check("single_core_a", core_a, 256'h2);
        check("single_core_d", core_d, 256'h5);
        check("single_core_n", core_n, 256'hB);
        check("single_grant", 256'(grant_id), 256'(1'b1));
        check("single_busy", 256'(busy), 256'(1'b1));
        viol = 0;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (core_start !== 1'b0 || req_ready !== 2'b00 || resp_valid !== 2'b00) viol++;
        end
        check("single_wait_quiet", 256'(viol), 256'(0));
        core_result = 256'hA;
        core_finished = 1'b1;
        tick();
        core_finished = 1'b0;
        check("single_resp_valid", 256'(resp_valid), 256'(2'b10));
        check("single_resp_data", resp_data, 256'hA);
        resp_ready = 2'b01;  // non-owner ready must be ignored
        tick(); tick();
        check("single_resp_hold", 256'(resp_valid), 256'(2'b10));
        check("single_core_a_stable", core_a, 256'h2);
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;
        check("single_resp_clear", 256'(resp_valid), 256'(2'b00));
        check("single_idle_busy", 256'(busy), 256'(1'b0));

        // both requesters valid: grants alternate 0,1,0,1
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            exp_g  = (j % 2 == 0) ? 2'd0 : 2'd1;
            exp_oh = (j % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check("rr_req_ready", 256'(req_ready), 256'(exp_oh));
            tick();
            check("rr_start", 256'(core_start), 256'(1'b1));
            check("rr_grant", 256'(grant_id), 256'(exp_g));
            check("rr_core_a", core_a, (j % 2 == 0) ? 256'h3 : 256'h2);
            tick();
            check("rr_start_low", 256'(core_start), 256'(1'b0));
            core_result = 256'h100 + 256'(j);
            core_finished = 1'b1;
            tick();
            core_finished = 1'b0;
            check("rr_resp_owner", 256'(resp_valid), 256'(exp_oh));
            check("rr_resp_data", resp_data, 256'h100 + 256'(j));
            if (j == 0) begin
                viol = 0;
                for (int c = 0; c < 20; c++) begin
                    tick();
                    if (resp_data !== 256'h100 || req_ready !== 2'b00 ||
                        core_start !== 1'b0 || resp_valid !== 2'b01) viol++;
                end
                check("bp_stable", 256'(viol), 256'(0));
            end
            resp_ready = exp_oh;
            tick();
            resp_ready = 2'b00;
        end
        req_valid = 2'b00;
        #1;
        check("rr_done_idle", 256'(busy), 256'(1'b0));

        // spurious finish in IDLE, then in ISSUE
        core_result = 256'h55;
        core_finished = 1'b1;
        tick();
        core_finished = 1'b0;
        check("spur_idle_busy", 256'(busy), 256'(1'b0));
        check("spur_idle_resp", 256'(resp_valid), 256'(2'b00));
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        check("spur_issue_start", 256'(core_start), 256'(1'b1));
        core_finished = 1'b1;
        tick();
        core_finished = 1'b0;
        check("spur_issue_resp", 256'(resp_valid), 256'(2'b00));
        check("spur_issue_busy", 256'(busy), 256'(1'b1));
        tick(); tick();
        check("spur_busy_wait", 256'(resp_valid), 256'(2'b00));
        core_result = 256'h66;
        core_finished = 1'b1;
        tick();
        core_finished = 1'b0;
        check("spur_real_resp", 256'(resp_valid), 256'(2'b01));
        check("spur_real_data", resp_data, 256'h66);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;

        // reset in the middle of BUSY
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        check("mid_start", 256'(core_start), 256'(1'b1));
        for (int c = 0; c < 5; c++) tick();
        avm_rst = 1'b1;
        #1;
        check("mid_rst_busy", 256'(busy), 256'(1'b0));
        check("mid_rst_grant", 256'(grant_id), 256'(1'b0));
        check("mid_rst_core_a", core_a, 256'(0));
        check("mid_rst_resp_data", resp_data, 256'(0));
        check("mid_rst_resp_valid", 256'(resp_valid), 256'(2'b00));
        tick();
        core_finished = 1'b1;
        tick();
        core_finished = 1'b0;
        avm_rst = 1'b0;
        tick();
        check("mid_post_resp", 256'(resp_valid), 256'(2'b00));
        req_valid = 2'b11;
        #1;
        check("mid_post_first0", 256'(req_ready), 256'(2'b01));
        tick();
        req_valid = 2'b00;
        check("mid_post_grant", 256'(grant_id), 256'(1'b0));
        check("mid_post_core_a", core_a, 256'h3);

        // NUM_REQ=3: requesters 2 and 0 valid, last grant starts at 2
        r3_a = {8'h12, 8'h11, 8'h10};
        r3_valid = 3'b101;
        for (int j = 0; j < 3; j++) begin
            exp3_g  = (j == 1) ? 2'd2 : 2'd0;
            exp3_oh = (j == 1) ? 3'b100 : 3'b001;
            #1;
            check("w3_req_ready", 256'(r3_ready), 256'(exp3_oh));
            tick();
            check("w3_grant", 256'(r3_grant_id), 256'(exp3_g));
            check("w3_core_a", 256'(r3_core_a), (j == 1) ? 256'h12 : 256'h10);
            tick();
            r3_core_result = 8'h40 + 8'(j);
            r3_core_finished = 1'b1;
            tick();
            r3_core_finished = 1'b0;
            check("w3_resp_owner", 256'(r3_resp_valid), 256'(exp3_oh));
            check("w3_resp_data", 256'(r3_resp_data), 256'h40 + 256'(j));
            r3_resp_ready = exp3_oh;
            tick();
            r3_resp_ready = 3'b000;
        end
        r3_valid = 3'b000;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
